io_confirmation_unit: RTL and testbench

//   Board-side I/O handshake stage between the user pushbutton/switches and ControlCore.

---
 rtl/io_confirmation_unit_if.sv | 26 ++
 rtl/io_confirmation_unit.sv | 116 +++++++++++
 tb/tb_io_confirmation_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/io_confirmation_unit_if.sv
// rtl/io_confirmation_unit_if.sv - ControlCore-side handshake bundle for the I/O confirmation unit
interface io_confirmation_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  is_output;
    logic                  is_input;
    logic [DATA_WIDTH-1:0] output_data;
    logic                  confirmation;
    logic [DATA_WIDTH-1:0] input_data;

    modport master (
        output is_output,
        output is_input,
        output output_data,
        input  confirmation,
        input  input_data
    );

    modport slave (
        input  is_output,
        input  is_input,
        input  output_data,
        output confirmation,
        output input_data
    );
endinterface

// File: rtl/io_confirmation_unit.sv
// rtl/io_confirmation_unit.sv - pushbutton confirmation handshake for OUTSS, switch sampling for INSW
module io_confirmation_unit #(
    parameter int DATA_WIDTH      = 32,
    parameter int SWITCH_WIDTH    = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    button_raw,
    input  logic [SWITCH_WIDTH-1:0] switches_raw,
    io_confirmation_unit_if.slave   core,
    output logic                    waiting,
    output logic [DATA_WIDTH-1:0]   display_value
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_PRESS = 2'd1,
        ST_ACK        = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_capture;
    logic                    r_btn_s1;
    logic                    r_btn_s2;
    logic                    r_btn_db;
    logic [CW-1:0]           r_db_cnt;
    logic [SWITCH_WIDTH-1:0] r_sw_s1;
    logic [SWITCH_WIDTH-1:0] r_sw_s2;
    logic                    r_confirmation;
    logic                    r_waiting;
    logic [DATA_WIDTH-1:0]   r_display;
    logic [DATA_WIDTH-1:0]   w_input_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_btn_s1 <= button_raw;
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= switches_raw;
            r_sw_s2  <= r_sw_s1;
        end
    end

    // The level is only accepted after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_btn_db <= 1'b0;
            r_db_cnt <= '0;
        end else if (r_btn_s2 != r_btn_db) begin
            if (r_db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_btn_db <= r_btn_s2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    // Entering the wait requires a released button, so a held press never confirms a new OUTSS.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (core.is_output && !r_btn_db) begin
                    w_next    = ST_WAIT_PRESS;
                    w_capture = 1'b1;
                end
            end
            ST_WAIT_PRESS: begin
                if (!core.is_output) begin
                    w_next = ST_IDLE;
                end else if (r_btn_db) begin
                    w_next = ST_ACK;
                end
            end
            ST_ACK:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_confirmation <= 1'b0;
            r_waiting      <= 1'b0;
            r_display      <= '0;
        end else begin
            r_state        <= w_next;
            r_confirmation <= (w_next == ST_ACK);
            r_waiting      <= (w_next == ST_WAIT_PRESS);
            if (w_capture) begin
                r_display <= core.output_data;
            end
        end
    end

    always_comb begin
        w_input_data                   = '0;
        w_input_data[SWITCH_WIDTH-1:0] = r_sw_s2;
    end

    assign core.confirmation = r_confirmation;
    assign core.input_data   = w_input_data;
    assign waiting           = r_waiting;
    assign display_value     = r_display;
endmodule

// File: tb/tb_io_confirmation_unit.sv
// tb/tb_io_confirmation_unit.sv - directed vector bench for io_confirmation_unit
module tb_io_confirmation_unit;
    localparam int DW = 32;
    localparam int SW = 16;
    localparam int DB = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          button_raw;
    logic [SW-1:0] switches_raw;
    logic          waiting;
    logic [DW-1:0] display_value;

    io_confirmation_unit_if #(.DATA_WIDTH(DW)) core_if ();

    io_confirmation_unit #(
        .DATA_WIDTH(DW), .SWITCH_WIDTH(SW), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clock(clock), .reset(reset), .button_raw(button_raw),
        .switches_raw(switches_raw), .core(core_if.slave),
        .waiting(waiting), .display_value(display_value)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          rst;
        logic          btn;
        logic [SW-1:0] sw;
        logic          iso;
        logic          isi;
        logic [DW-1:0] od;
        logic          conf;
        logic          wt;
        logic [DW-1:0] disp;
        logic [DW-1:0] ind;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic btn, input logic [SW-1:0] sw,
                         input logic iso, input logic isi, input logic [DW-1:0] od);
        reset             = rst;
        button_raw        = btn;
        switches_raw      = sw;
        core_if.is_output = iso;
        core_if.is_input  = isi;
        core_if.output_data = od;
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic add(input logic rst, input logic btn, input logic [SW-1:0] sw,
                       input logic iso, input logic isi, input logic [DW-1:0] od,
                       input logic conf, input logic wt, input logic [DW-1:0] disp,
                       input logic [DW-1:0] ind);
        vecs.push_back('{rst, btn, sw, iso, isi, od, conf, wt, disp, ind});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int       seen;
        int       pulses;
        logic     prev_conf;
        // Each row: inputs sampled at one rising edge, outputs expected after that edge.
        // T1: reset with button/switches active
        for (int i = 0; i < 3; i++) add(1, 1, 16'hFFFF, 1, 1, 32'hDEAD, 0, 0, 0, 0);
        add(0, 0, 16'h0, 0, 0, 32'h0, 0, 0, 0, 0);
        // T2: OUTSS capture then press at edge N (row 5), pulse after edge N+6
        add(0, 0, 16'h0, 1, 0, 32'h0000CAFE, 0, 1, 32'hCAFE, 0);
        for (int i = 0; i < 6; i++) add(0, 1, 16'h0, 1, 0, 32'h0000CAFE, 0, 1, 32'hCAFE, 0);
        add(0, 1, 16'h0, 1, 0, 32'h0000CAFE, 1, 0, 32'hCAFE, 0);
        // T4: held button with a new OUTSS stays idle, release needed
        add(0, 1, 16'h0, 1, 0, 32'h1234, 0, 0, 32'hCAFE, 0);
        add(0, 1, 16'h0, 1, 0, 32'h1234, 0, 0, 32'hCAFE, 0);
        for (int i = 0; i < 6; i++) add(0, 0, 16'h0, 1, 0, 32'h1234, 0, 0, 32'hCAFE, 0);
        add(0, 0, 16'h0, 1, 0, 32'h1234, 0, 1, 32'h1234, 0);
        // T3: 3-cycle glitch while waiting never confirms
        for (int i = 0; i < 3; i++) add(0, 1, 16'h0, 1, 0, 32'h1234, 0, 1, 32'h1234, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 16'h0, 1, 0, 32'h1234, 0, 1, 32'h1234, 0);
        // Abort: is_output drops, no pulse
        add(0, 0, 16'h0, 0, 0, 32'h1234, 0, 0, 32'h1234, 0);
        // T6: switches reach input_data two edges later; is_output wins when both high
        add(0, 0, 16'h00A5, 0, 1, 32'h0, 0, 0, 32'h1234, 0);
        add(0, 0, 16'h00A5, 0, 1, 32'h0, 0, 0, 32'h1234, 32'h000000A5);
        add(0, 0, 16'h00A5, 1, 1, 32'h5555, 0, 1, 32'h5555, 32'h000000A5);

        drive(1, 0, 16'h0, 0, 0, 32'h0);
        @(negedge clock);
        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].btn, vecs[k].sw, vecs[k].iso, vecs[k].isi, vecs[k].od);
            step();
            check($sformatf("v%0d confirmation", k), {31'b0, core_if.confirmation}, {31'b0, vecs[k].conf});
            check($sformatf("v%0d waiting", k), {31'b0, waiting}, {31'b0, vecs[k].wt});
            check($sformatf("v%0d display_value", k), display_value, vecs[k].disp);
            check($sformatf("v%0d input_data", k), core_if.input_data, vecs[k].ind);
        end

        // T5: reset while waiting with the button pressed
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 16'h00A5, 1, 0, 32'h5555);
            step();
            if (core_if.confirmation) pulses++;
        end
        drive(1, 1, 16'h00A5, 1, 0, 32'h5555);
        step();
        if (core_if.confirmation) pulses++;
        check("t5 waiting", {31'b0, waiting}, 32'h0);
        check("t5 display_value", display_value, 32'h0);
        check("t5 input_data", core_if.input_data, 32'h0);
        check("t5 no pulse", pulses, 0);

        // Full handshake after reset: exactly one pulse at edge N+6, display persists
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 16'h0, 0, 0, 32'h0);
            step();
        end
        drive(0, 0, 16'h0, 1, 0, 32'h0000ABCD);
        step();
        check("hs waiting", {31'b0, waiting}, 32'h1);
        check("hs display_value", display_value, 32'h0000ABCD);
        seen = 0;
        pulses = 0;
        prev_conf = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            drive(0, 1, 16'h0, 1, 0, 32'h0000ABCD);
            step();
            if (core_if.confirmation) begin
                pulses++;
                if (seen == 0) seen = i;
                if (prev_conf) begin
                    n_fail++;
                    $display("FAIL hs back-to-back confirmation at step %0d", i);
                end
            end
            prev_conf = core_if.confirmation;
        end
        check("hs pulse step", seen, 7);
        check("hs pulse count", pulses, 1);
        check("hs display persists", display_value, 32'h0000ABCD);
        check("hs waiting after ack", {31'b0, waiting}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
